// File: rtl/alu_wb_queue_if.sv
// rtl/alu_wb_queue_if.sv - ALU result intake and register-file write-back bundle
interface alu_wb_queue_if #(
  parameter int LEN_DATA = 64,
  parameter int DEPTH    = 4,
  parameter int REG_AW   = 5
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                en;
  logic                in_valid;
  logic [LEN_DATA-1:0] in_result;
  logic [LEN_DATA-1:0] in_ex_result;
  logic                in_cout;
  logic                in_dual;
  logic                in_setc;
  logic [REG_AW-1:0]   in_rd;
  logic [REG_AW-1:0]   in_rd_ex;
  logic                in_ready;

  logic                wr_valid;
  logic                wr_ready;
  logic [REG_AW-1:0]   wr_addr;
  logic [LEN_DATA-1:0] wr_data;

  logic                flag_we;
  logic                flag_c;
  logic                overflow;
  logic [CW-1:0]       count;

  modport slave (
    input  en, in_valid, in_result, in_ex_result, in_cout, in_dual, in_setc,
    input  in_rd, in_rd_ex, wr_ready,
    output in_ready, wr_valid, wr_addr, wr_data, flag_we, flag_c, overflow, count
  );

  modport master (
    output en, in_valid, in_result, in_ex_result, in_cout, in_dual, in_setc,
    output in_rd, in_rd_ex, wr_ready,
    input  in_ready, wr_valid, wr_addr, wr_data, flag_we, flag_c, overflow, count
  );
endinterface

// File: rtl/alu_wb_queue.sv
// rtl/alu_wb_queue.sv - ALU result queue draining one or two register writes per entry
module alu_wb_queue #(
  parameter int LEN_DATA = 64,
  parameter int DEPTH    = 4,
  parameter int REG_AW   = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_wb_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [LEN_DATA-1:0] result;
    logic [LEN_DATA-1:0] ex_result;
    logic                cout;
    logic                dual;
    logic                setc;
    logic [REG_AW-1:0]   rd;
    logic [REG_AW-1:0]   rd_ex;
  } entry_t;

  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  entry_t          mem_q [DEPTH];
  entry_t          head;
  state_t          state_q, state_d;
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;

  logic            in_ready;
  logic            push, pop, active, accept, zero_addr;
  logic [REG_AW-1:0] cur_addr;

  assign head     = mem_q[rptr_q];
  assign in_ready = (count_q < CW'(DEPTH));
  assign push     = bus.en & bus.in_valid & in_ready;
  assign active   = bus.en & (state_q != IDLE);
  assign cur_addr = (state_q == HI) ? head.rd_ex : head.rd;

  // Writes to register 0 are dropped but still consume their drain slot.
  assign zero_addr = (cur_addr == '0);
  assign accept    = active & (bus.wr_ready | zero_addr);
  assign pop       = accept & ((state_q == HI) | ((state_q == LO) & ~head.dual));

  always_comb begin
    wptr_d     = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d     = pop  ? rptr_q + 1'b1 : rptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    overflow_d = overflow_q | (bus.en & bus.in_valid & ~in_ready);
    state_d    = state_q;
    case (state_q)
      IDLE: if (bus.en && count_d != '0) state_d = LO;
      LO: begin
        if (accept) begin
          if (head.dual)             state_d = HI;
          else if (count_d != '0)    state_d = LO;
          else                       state_d = IDLE;
        end
      end
      HI: begin
        if (accept) state_d = (count_d != '0) ? LO : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Payload storage needs no reset: the valid window is set by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= '{result:    bus.in_result,
                         ex_result: bus.in_ex_result,
                         cout:      bus.in_cout,
                         dual:      bus.in_dual,
                         setc:      bus.in_setc,
                         rd:        bus.in_rd,
                         rd_ex:     bus.in_rd_ex};
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.wr_valid = active & ~zero_addr;
  assign bus.wr_addr  = (state_q == IDLE) ? '0 : cur_addr;
  assign bus.wr_data  = (state_q == IDLE) ? '0 :
                        (state_q == HI)   ? head.ex_result : head.result;
  assign bus.flag_we  = accept & (state_q == LO) & head.setc;
  assign bus.flag_c   = accept & (state_q == LO) & head.setc & head.cout;
  assign bus.overflow = overflow_q;
  assign bus.count    = count_q;
endmodule

// File: tb/tb_alu_wb_queue.sv
// tb/tb_alu_wb_queue.sv - scoreboard bench for alu_wb_queue
module tb_alu_wb_queue;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  alu_wb_queue_if #(.LEN_DATA(64), .DEPTH(4), .REG_AW(5)) bus ();

  alu_wb_queue #(.LEN_DATA(64), .DEPTH(4), .REG_AW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [4:0]  addr;
    logic [63:0] data;
    logic        fl;
    logic        fc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.wr_valid && bus.wr_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %0h required no write", bus.wr_addr, bus.wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 64'(bus.wr_addr), 64'(mon_e.addr));
        chk("wr_data", bus.wr_data, mon_e.data);
        chk("flag_we", 64'(bus.flag_we), 64'(mon_e.fl));
        chk("flag_c", 64'(bus.flag_c), 64'(mon_e.fc));
      end
    end
    if (rst_n && bus.flag_we && !(bus.wr_valid && bus.wr_ready))
      chk("flag_we_without_write", 64'(bus.flag_we), 64'd0);
  end

  task automatic push(input logic [63:0] r, input logic [63:0] x, input logic c, input logic d,
                      input logic s, input logic [4:0] a, input logic [4:0] ax, input bit acc);
    exp_t t;
    @(posedge clk); #1;
    bus.in_valid     = 1'b1;
    bus.in_result    = r;
    bus.in_ex_result = x;
    bus.in_cout      = c;
    bus.in_dual      = d;
    bus.in_setc      = s;
    bus.in_rd        = a;
    bus.in_rd_ex     = ax;
    if (acc) begin
      if (a != 5'd0) begin
        t.addr = a; t.data = r; t.fl = s; t.fc = s & c;
        exp_q.push_back(t);
      end
      if (d && ax != 5'd0) begin
        t.addr = ax; t.data = x; t.fl = 1'b0; t.fc = 1'b0;
        exp_q.push_back(t);
      end
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string nm, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk(nm, 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_valid"}, 64'(bus.wr_valid), 64'd0);
    chk({tag, "_wr_addr"}, 64'(bus.wr_addr), 64'd0);
    chk({tag, "_wr_data"}, bus.wr_data, 64'd0);
    chk({tag, "_flag_we"}, 64'(bus.flag_we), 64'd0);
    chk({tag, "_flag_c"}, 64'(bus.flag_c), 64'd0);
    chk({tag, "_overflow"}, 64'(bus.overflow), 64'd0);
    chk({tag, "_count"}, 64'(bus.count), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.en = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_result = '0;
    bus.in_ex_result = '0;
    bus.in_cout = 1'b0;
    bus.in_dual = 1'b0;
    bus.in_setc = 1'b0;
    bus.in_rd = '0;
    bus.in_rd_ex = '0;
    bus.wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    rst_n = 1'b1;

    // single write, latency one cycle
    push(64'h1, 64'h0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd0, 1'b1);
    idle();
    @(negedge clk);
    chk("single_wr_valid", 64'(bus.wr_valid), 64'd1);
    chk("single_wr_addr", 64'(bus.wr_addr), 64'd3);
    @(posedge clk); #1;
    chk("single_count", 64'(bus.count), 64'd0);
    @(negedge clk);
    chk("single_idle_wr_valid", 64'(bus.wr_valid), 64'd0);

    // dual with carry update on the first write only
    push(64'hAAAA_0000_1234_5678, 64'hBBBB_0000_9ABC_DEF0, 1'b1, 1'b1, 1'b1, 5'd4, 5'd5, 1'b1);
    idle();
    @(negedge clk);
    chk("dual_lo_addr", 64'(bus.wr_addr), 64'd4);
    chk("dual_lo_flag_we", 64'(bus.flag_we), 64'd1);
    @(negedge clk);
    chk("dual_hi_valid", 64'(bus.wr_valid), 64'd1);
    chk("dual_hi_addr", 64'(bus.wr_addr), 64'd5);
    chk("dual_hi_flag_we", 64'(bus.flag_we), 64'd0);
    drain("dual_drain", 20);

    // first write to register 0 is suppressed
    push(64'h0DEA_D000, 64'h0000_7777, 1'b0, 1'b1, 1'b0, 5'd0, 5'd7, 1'b1);
    idle();
    drain("zero_drain", 20);
    chk("zero_count", 64'(bus.count), 64'd0);

    // back-to-back pushes wrap the pointers
    for (int i = 0; i < 10; i++) begin
      push(64'h0101 * i + 64'h5, 64'h0, 1'b0, 1'b0, 1'b0, 5'((i % 7) + 1), 5'd0, 1'b1);
      if (i > 0) begin
        @(negedge clk);
        chk("stream_count", 64'(bus.count), 64'd1);
      end
    end
    idle();
    drain("stream_drain", 20);
    chk("stream_overflow", 64'(bus.overflow), 64'd0);

    // fill with the sink stalled, then overflow
    bus.wr_ready = 1'b0;
    for (int i = 0; i < 6; i++)
      push(64'hC000 + 64'(i), 64'h0, 1'b0, 1'b0, 1'b0, 5'(10 + i), 5'd0, (i < 4));
    idle();
    chk("full_count", 64'(bus.count), 64'd4);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    chk("full_overflow", 64'(bus.overflow), 64'd1);
    bus.wr_ready = 1'b1;
    drain("full_drain", 40);
    chk("full_count_after", 64'(bus.count), 64'd0);
    chk("overflow_sticky", 64'(bus.overflow), 64'd1);

    // reset while in HI with three entries queued
    bus.wr_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      push(64'h100 + 64'(i), 64'h200 + 64'(i), 1'b0, 1'b1, 1'b0, 5'(2 * i + 1), 5'(2 * i + 2), 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.wr_ready = 1'b1;
    @(posedge clk); #1;
    bus.wr_ready = 1'b0;
    chk("hi_count", 64'(bus.count), 64'd3);
    chk("hi_wr_addr", 64'(bus.wr_addr), 64'd2);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk_reset_outputs("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.wr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_reset_wr_valid", 64'(bus.wr_valid), 64'd0);
    end
    push(64'h5A5A, 64'h0, 1'b0, 1'b0, 1'b0, 5'd9, 5'd0, 1'b1);
    idle();
    drain("post_reset_drain", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
